axi_rdata_2_bram_wdata: RTL and testbench

- Reverse of the BRAM-to-AXI write-data path. Accepts 32-bit beats from an AXI4-FULL read data channel and packs each pair into one 64-bit word.
- Writes packed words sequentially into BRAM port A, starting at address 0.
- One transfer runs per rising edge of stage_start, for TOTAL_NUM beats; completion is signalled by a one-cycle stage_done pulse.

---
 rtl/axi_bram_pkg.sv | 20 ++
 rtl/beat_packer_32to64.sv | 51 +++++
 rtl/axi_rdata_2_bram_wdata.sv | 147 ++++++++++++++
 tb/tb_axi_rdata_2_bram_wdata.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/axi_bram_pkg.sv
// Shared types and widths for the AXI read-data to BRAM write-data path.
package axi_bram_pkg;

    localparam int unsigned AXI_DW  = 32;
    localparam int unsigned BRAM_DW = 64;
    localparam int unsigned BRAM_AW = 14;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Two 32-bit beats share one 64-bit BRAM word.
    function automatic logic [BRAM_AW-1:0] word_addr(input logic [BRAM_AW-1:0] beat_idx);
        return beat_idx >> 1;
    endfunction

endpackage

// File: rtl/beat_packer_32to64.sv
// Packs pairs of 32-bit beats into 64-bit words; the first beat of a pair lands in [63:32].
module beat_packer_32to64
    import axi_bram_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               clear_i,
    input  logic               beat_valid_i,
    input  logic [AXI_DW-1:0]  beat_data_i,
    input  logic               flush_i,
    output logic               word_valid_o,
    output logic [BRAM_DW-1:0] word_data_o
);

    logic [AXI_DW-1:0]  half_hi_q;
    logic               odd_q;
    logic               word_valid_q;
    logic [BRAM_DW-1:0] word_data_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            half_hi_q    <= '0;
            odd_q        <= 1'b0;
            word_valid_q <= 1'b0;
            word_data_q  <= '0;
        end else begin
            word_valid_q <= 1'b0;
            if (clear_i) begin
                half_hi_q <= '0;
                odd_q     <= 1'b0;
            end else if (flush_i) begin
                // Unpaired trailing beat is written with a zero low half.
                word_valid_q <= 1'b1;
                word_data_q  <= {half_hi_q, {AXI_DW{1'b0}}};
                odd_q        <= 1'b0;
            end else if (beat_valid_i) begin
                if (odd_q) begin
                    word_valid_q <= 1'b1;
                    word_data_q  <= {half_hi_q, beat_data_i};
                end else begin
                    half_hi_q <= beat_data_i;
                end
                odd_q <= ~odd_q;
            end
        end
    end

    assign word_valid_o = word_valid_q;
    assign word_data_o  = word_data_q;

endmodule

// File: rtl/axi_rdata_2_bram_wdata.sv
// Receives TOTAL_NUM AXI read beats per stage and writes them as 64-bit words to BRAM port A.
// Optional RLAST checking is enabled with `define RD_LAST_CHECK_EN.
module axi_rdata_2_bram_wdata
    import axi_bram_pkg::*;
#(
    parameter int unsigned TOTAL_NUM = 1536
) (
    input  logic               axi_ACLK,
    input  logic               axi_ARESETN,
    input  logic               stage_start,
    input  logic [AXI_DW-1:0]  read_data,
    input  logic               read_valid,
    input  logic               read_last,
    output logic               read_ready,
    output logic               bram_ena,
    output logic               bram_wea,
    output logic [BRAM_AW-1:0] bram_addra,
    output logic [BRAM_DW-1:0] bram_dina,
    output logic               stage_done,
    output logic               rd_err
);

    localparam logic [BRAM_AW-1:0] LastBeat  = BRAM_AW'(TOTAL_NUM - 1);
    localparam logic [BRAM_AW-1:0] FlushAddr = BRAM_AW'(TOTAL_NUM / 2);
    localparam bit                 TotalOdd  = (TOTAL_NUM % 2) == 1;

    state_e             state_q;
    logic [BRAM_AW-1:0] beat_cnt_q;
    logic [BRAM_AW-1:0] addr_q;
    logic               stage_start_q;
    logic               read_ready_q;
    logic               stage_done_q;
    logic               done_pending_q;

    logic               start_pulse;
    logic               accept;
    logic               abort;
    logic               pack_clear;
    logic               pack_flush;
    logic               word_valid;
    logic [BRAM_DW-1:0] word_data;

    assign start_pulse = stage_start & ~stage_start_q;
    // Gating on stage_start keeps a beat arriving in the abort cycle out of the packer.
    assign accept      = read_valid & read_ready_q & stage_start & (state_q == RECV);
    assign abort       = ~stage_start & ((state_q == RECV) | (state_q == FLUSH));
    assign pack_clear  = ((state_q == IDLE) & start_pulse) | abort;
    assign pack_flush  = (state_q == FLUSH) & stage_start;

    always_ff @(posedge axi_ACLK or negedge axi_ARESETN) begin
        if (!axi_ARESETN) begin
            state_q        <= IDLE;
            beat_cnt_q     <= '0;
            addr_q         <= '0;
            stage_start_q  <= 1'b0;
            read_ready_q   <= 1'b0;
            stage_done_q   <= 1'b0;
            done_pending_q <= 1'b0;
        end else begin
            stage_start_q <= stage_start;
            stage_done_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start_pulse) begin
                        state_q        <= RECV;
                        beat_cnt_q     <= '0;
                        read_ready_q   <= 1'b1;
                        done_pending_q <= 1'b0;
                    end
                end
                RECV: begin
                    if (!stage_start) begin
                        state_q      <= IDLE;
                        read_ready_q <= 1'b0;
                    end else if (accept) begin
                        beat_cnt_q <= beat_cnt_q + 1'b1;
                        if (beat_cnt_q[0]) begin
                            addr_q <= word_addr(beat_cnt_q);
                        end
                        if (beat_cnt_q == LastBeat) begin
                            read_ready_q   <= 1'b0;
                            state_q        <= TotalOdd ? FLUSH : DONE;
                            done_pending_q <= !TotalOdd;
                        end
                    end
                end
                FLUSH: begin
                    if (!stage_start) begin
                        state_q <= IDLE;
                    end else begin
                        addr_q         <= FlushAddr;
                        state_q        <= DONE;
                        done_pending_q <= 1'b1;
                    end
                end
                DONE: begin
                    // Pulse lands in the cycle after the final write strobe.
                    stage_done_q   <= done_pending_q;
                    done_pending_q <= 1'b0;
                    if (!stage_start) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    beat_packer_32to64 u_packer (
        .clk_i        (axi_ACLK),
        .rst_ni       (axi_ARESETN),
        .clear_i      (pack_clear),
        .beat_valid_i (accept),
        .beat_data_i  (read_data),
        .flush_i      (pack_flush),
        .word_valid_o (word_valid),
        .word_data_o  (word_data)
    );

`ifdef RD_LAST_CHECK_EN
    logic rd_err_q;

    always_ff @(posedge axi_ACLK or negedge axi_ARESETN) begin
        if (!axi_ARESETN) begin
            rd_err_q <= 1'b0;
        end else if ((state_q == IDLE) && start_pulse) begin
            rd_err_q <= 1'b0;
        end else if (accept && (read_last != (beat_cnt_q == LastBeat))) begin
            rd_err_q <= 1'b1;
        end
    end

    assign rd_err = rd_err_q;
`else
    logic unused_read_last;
    assign unused_read_last = read_last;
    assign rd_err           = 1'b0;
`endif

    assign read_ready = read_ready_q;
    assign bram_ena   = word_valid;
    assign bram_wea   = word_valid;
    assign bram_addra = addr_q;
    assign bram_dina  = word_data;
    assign stage_done = stage_done_q;

endmodule

// File: tb/tb_axi_rdata_2_bram_wdata.sv
// Bench for axi_rdata_2_bram_wdata: four instances with different TOTAL_NUM, table of stage runs.
module tb_axi_rdata_2_bram_wdata;

    localparam int unsigned TN [4] = '{4, 3, 8, 1536};
`ifdef RD_LAST_CHECK_EN
    localparam bit ErrOn = 1'b1;
`else
    localparam bit ErrOn = 1'b0;
`endif

    typedef struct {
        int          inst;
        bit          toggle;
        int          abort_after;
        int          rst_after;
        int          bad_last;
        logic [31:0] base;
        logic [31:0] stride;
        int          exp_done;
        bit          exp_err;
    } case_t;

    typedef struct {
        logic [13:0] addr;
        logic [63:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  start;
    logic [31:0] read_data;
    logic        read_valid;
    logic        read_last;
    logic [3:0]  rr, ena, wea, done, err;
    logic [13:0] addr [4];
    logic [63:0] din [4];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        axi_rdata_2_bram_wdata #(.TOTAL_NUM(TN[g])) u_dut (
            .axi_ACLK    (clk),
            .axi_ARESETN (rst_n),
            .stage_start (start[g]),
            .read_data   (read_data),
            .read_valid  (read_valid),
            .read_last   (read_last),
            .read_ready  (rr[g]),
            .bram_ena    (ena[g]),
            .bram_wea    (wea[g]),
            .bram_addra  (addr[g]),
            .bram_dina   (din[g]),
            .stage_done  (done[g]),
            .rd_err      (err[g])
        );
    end

    wr_t   exp_q [$];
    int    tests    = 0;
    int    errors   = 0;
    int    cyc      = 0;
    int    last_wr  = -10;
    int    done_cnt = 0;
    int    wr_cnt   = 0;
    int    sel      = 0;
    case_t cases [9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Advance to the next falling edge and score any write/done from the selected instance.
    task automatic tick();
        wr_t w;
        @(negedge clk);
        cyc++;
        if (done[sel]) begin
            chk("done_one_cycle_after_last_write", 64'(cyc - last_wr), 64'd1);
            done_cnt++;
        end
        if (ena[sel]) begin
            wr_cnt++;
            last_wr = cyc;
            chk("wea_with_ena", 64'(wea[sel]), 64'd1);
            if (exp_q.size() == 0) begin
                tests++;
                errors++;
                $display("FAIL unexpected_write: got addr %0h data %h, expected no write",
                         addr[sel], din[sel]);
            end else begin
                w = exp_q.pop_front();
                chk("bram_addra", 64'(addr[sel]), 64'(w.addr));
                chk("bram_dina", din[sel], w.data);
            end
        end
    endtask

    task automatic run_case(input int id, input case_t c);
        int          n;
        int          k;
        int          pushed;
        int          d0;
        int          w0;
        bit          stopped;
        logic [31:0] d;
        logic [31:0] hi;
        wr_t         w;
        n       = int'(TN[c.inst]);
        k       = 0;
        pushed  = 0;
        stopped = 1'b0;
        hi      = '0;
        sel     = c.inst;
        d0      = done_cnt;
        w0      = wr_cnt;
        read_valid = 1'b0;
        start[sel] = 1'b1;
        tick();
        for (int cy = 0; cy < 4 * n + 50 && !stopped; cy++) begin
            if (k == c.abort_after) begin
                start[sel] = 1'b0;
                read_valid = 1'b0;
                stopped    = 1'b1;
            end else if (k == c.rst_after) begin
                #2 rst_n = 1'b0;
                #1;
                chk($sformatf("case%0d_rst_read_ready", id), 64'(rr[sel]), 64'd0);
                chk($sformatf("case%0d_rst_bram_ena", id), 64'(ena[sel]), 64'd0);
                chk($sformatf("case%0d_rst_bram_wea", id), 64'(wea[sel]), 64'd0);
                chk($sformatf("case%0d_rst_stage_done", id), 64'(done[sel]), 64'd0);
                start[sel] = 1'b0;
                read_valid = 1'b0;
                tick();
                rst_n   = 1'b1;
                stopped = 1'b1;
            end else if (k == n) begin
                chk($sformatf("case%0d_read_ready_after_last", id), 64'(rr[sel]), 64'd0);
                stopped = 1'b1;
            end else begin
                d          = c.base + 32'(k) * c.stride;
                read_valid = c.toggle ? (cy % 2 == 0) : 1'b1;
                read_data  = d;
                read_last  = (c.bad_last >= 0) ? (k == c.bad_last) : (k == n - 1);
                if (read_valid && rr[sel]) begin
                    if (k % 2 == 0) begin
                        hi = d;
                    end else begin
                        w.addr = 14'(k / 2);
                        w.data = {hi, d};
                        exp_q.push_back(w);
                        pushed++;
                    end
                    if (k == n - 1 && n % 2 == 1) begin
                        w.addr = 14'(k / 2);
                        w.data = {hi, 32'h0};
                        exp_q.push_back(w);
                        pushed++;
                    end
                    k++;
                end
                tick();
            end
        end
        if (!stopped) begin
            tests++;
            errors++;
            $display("FAIL case%0d_timeout: got %0d beats accepted, expected %0d", id, k, n);
        end
        // Offer a stray beat after completion; it must not be taken.
        read_data  = 32'hDEADBEEF;
        read_valid = (k == n);
        read_last  = 1'b0;
        repeat (6) tick();
        read_valid = 1'b0;
        chk($sformatf("case%0d_read_ready_idle", id), 64'(rr[sel]), 64'd0);
        chk($sformatf("case%0d_pending_writes", id), 64'(exp_q.size()), 64'd0);
        chk($sformatf("case%0d_done_count", id), 64'(done_cnt - d0), 64'(c.exp_done));
        chk($sformatf("case%0d_write_count", id), 64'(wr_cnt - w0), 64'(pushed));
        chk($sformatf("case%0d_rd_err", id), 64'(err[sel]), 64'(c.exp_err));
        start[sel] = 1'b0;
        repeat (3) tick();
        chk($sformatf("case%0d_rd_err_held", id), 64'(err[sel]), 64'(c.exp_err));
        exp_q.delete();
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = '0;
        read_data  = '0;
        read_valid = 1'b0;
        read_last  = 1'b0;

        cases[0] = '{0, 1'b0, -1, -1, -1, 32'h11111111, 32'h11111111, 1, 1'b0};
        cases[1] = '{1, 1'b0, -1, -1, -1, 32'hA0000001, 32'h0F0F0F0F, 1, 1'b0};
        cases[2] = '{3, 1'b1, -1, -1, -1, 32'hC0DE0000, 32'h00000001, 1, 1'b0};
        cases[3] = '{2, 1'b0,  5, -1, -1, 32'h50000000, 32'h00000101, 0, 1'b0};
        cases[4] = '{2, 1'b0, -1, -1, -1, 32'h60000000, 32'h00001111, 1, 1'b0};
        cases[5] = '{0, 1'b0, -1, -1,  2, 32'h70000000, 32'h00000003, 1, ErrOn};
        cases[6] = '{0, 1'b0, -1, -1, -1, 32'h80000000, 32'h00000005, 1, 1'b0};
        cases[7] = '{2, 1'b0, -1,  2, -1, 32'h90000000, 32'h00000007, 0, 1'b0};
        cases[8] = '{2, 1'b0, -1, -1, -1, 32'hA5A50000, 32'h00000009, 1, 1'b0};

        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("reset_read_ready%0d", i), 64'(rr[i]), 64'd0);
            chk($sformatf("reset_bram_ena%0d", i), 64'(ena[i]), 64'd0);
            chk($sformatf("reset_stage_done%0d", i), 64'(done[i]), 64'd0);
        end
        chk("reset_bram_addra", 64'(addr[0]), 64'd0);
        chk("reset_bram_dina", din[0], 64'd0);
        chk("reset_rd_err", 64'(err[0]), 64'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 9; i++) begin
            run_case(i, cases[i]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
